// File: rtl/den_norm_seq.sv
// -----------------------------------------------------------------------------
// DenNormSeq: sequential normaliser for the unsigned CORDIC divide denominator.
//
// Shifts an unsigned W-bit operand until it lies in [2^(W-2), 2^(W-1)) and
// reports the signed shift that was applied, so the downstream stage can
// de-normalise the quotient. The operand is zero-detected. Left shifting
// saturates at MAX_SHIFT. Values with the MSB set are right-shifted once.
//
// Optional build macro: DEN_NORM_STEP4_EN
//   When defined, a left shift takes four bits in one cycle whenever that
//   cannot overshoot the window or MAX_SHIFT. Results are unchanged; only
//   the latency is shorter.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   den_in is valid
//   in_ready   block can accept an operand (IDLE only)
//   den_in     unsigned denominator, W bits
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts result
//   den_out    normalised value, W bits
//   shift_out  signed shift count, SW bits (+k = k left shifts, -1 = one right)
//   zero_out   den_in was zero
//   sat_out    left shifting stopped at MAX_SHIFT before reaching the window
// -----------------------------------------------------------------------------
module den_norm_seq #(
  parameter int W         = 16,
  parameter int MAX_SHIFT = W - 2,
  parameter int SW        = $clog2(W) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  den_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  den_out,
  output logic [SW-1:0] shift_out,
  output logic          zero_out,
  output logic          sat_out
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [SW-1:0] MAX_CNT = SW'(MAX_SHIFT);

  state_t        state;
  logic [W-1:0]  value;
  logic [SW-1:0] cnt;

`ifdef DEN_NORM_STEP4_EN
  // A four-bit step is safe when the top five bits are clear: the operand
  // then needs at least four more shifts to reach the window, so stepping
  // by four lands exactly where four single steps would have. The counter
  // check keeps saturation at the same place as the one-bit build.
  logic step4;

  generate
    if (W >= 5) begin : g_step4
      logic [SW:0] cnt_plus4;
      assign cnt_plus4 = {1'b0, cnt} + (SW+1)'(4);
      assign step4 = (value[W-1 -: 5] == 5'd0) &&
                     (cnt_plus4 <= (SW+1)'(MAX_SHIFT));
    end else begin : g_no_step4
      assign step4 = 1'b0;
    end
  endgenerate
`endif

  // Single state machine: captures the operand, shifts it one step per
  // clock, and registers the result and handshake outputs on DONE entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      value     <= '0;
      cnt       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      den_out   <= '0;
      shift_out <= '0;
      zero_out  <= 1'b0;
      sat_out   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            value    <= den_in;
            cnt      <= '0;
            zero_out <= 1'b0;
            sat_out  <= 1'b0;
            in_ready <= 1'b0;
            state    <= SHIFT;
          end
        end

        SHIFT: begin
          if (value == '0) begin
            zero_out  <= 1'b1;
            den_out   <= '0;
            shift_out <= '0;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (value[W-1]) begin
            // One right shift always lands in the window.
            value     <= value >> 1;
            den_out   <= value >> 1;
            shift_out <= '1;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (value[W-2]) begin
            den_out   <= value;
            shift_out <= cnt;
            out_valid <= 1'b1;
            state     <= DONE;
          end else if (cnt == MAX_CNT) begin
            sat_out   <= 1'b1;
            den_out   <= value;
            shift_out <= cnt;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef DEN_NORM_STEP4_EN
          end else if (step4) begin
            value <= value << 4;
            cnt   <= cnt + SW'(4);
`endif
          end else begin
            value <= value << 1;
            cnt   <= cnt + SW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_den_norm_seq.sv
// -----------------------------------------------------------------------------
// Testbench for den_norm_seq. Two instances (MAX_SHIFT=14 and MAX_SHIFT=8,
// both W=16) share clock and reset. Directed vectors come from a table,
// random operands are checked against an arithmetic reference model, and
// hand-written sequences cover output back-pressure and mid-operation reset.
// The expected latency follows DEN_NORM_STEP4_EN if it is defined.
// -----------------------------------------------------------------------------
module tb_den_norm_seq;

  localparam int W  = 16;
  localparam int SW = 5;

`ifdef DEN_NORM_STEP4_EN
  localparam bit STEP4 = 1'b1;
`else
  localparam bit STEP4 = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  logic          in_valid  [2];
  logic          in_ready  [2];
  logic [W-1:0]  den_in    [2];
  logic          out_valid [2];
  logic          out_ready [2];
  logic [W-1:0]  den_out   [2];
  logic [SW-1:0] shift_out [2];
  logic          zero_out  [2];
  logic          sat_out   [2];

  int errors = 0;
  int checks = 0;

  int maxShift [2] = '{14, 8};

  always #5 clk = ~clk;

  den_norm_seq #(.W(16), .MAX_SHIFT(14)) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .den_in(den_in[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .den_out(den_out[0]),
    .shift_out(shift_out[0]), .zero_out(zero_out[0]), .sat_out(sat_out[0])
  );

  den_norm_seq #(.W(16), .MAX_SHIFT(8)) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .den_in(den_in[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .den_out(den_out[1]),
    .shift_out(shift_out[1]), .zero_out(zero_out[1]), .sat_out(sat_out[1])
  );

  typedef struct {
    int          unit;
    logic [15:0] den;
    int          expDen;
    int          expShift;
    bit          expZero;
    bit          expSat;
    int          expLat;
  } vec_t;

  // Latency in cycles after the transfer cycle for k left shifts.
  function automatic int leftLatency(input int k);
    if (STEP4) return 2 + k / 4 + k % 4;
    return 2 + k;
  endfunction

  // Reference: find the MSB, derive how many left shifts reach the window,
  // clamp to the saturation limit.
  task automatic refModel(input logic [15:0] x, input int maxs,
                          output int d, output int sh, output bit z,
                          output bit s, output int lat);
    int msb;
    int need;
    int k;
    z = 1'b0; s = 1'b0;
    if (x == 16'd0) begin
      d = 0; sh = 0; z = 1'b1; lat = 2;
    end else if (x >= 16'd32768) begin
      d = int'(x) / 2; sh = -1; lat = 2;
    end else begin
      msb = 0;
      for (int i = 0; i < 16; i++) if (x[i]) msb = i;
      need = 14 - msb;
      k = (need < maxs) ? need : maxs;
      s = (need > maxs);
      d = int'(x) * (1 << k);
      sh = k;
      lat = leftLatency(k);
    end
  endtask

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Offers one operand, waits for the transfer, then counts cycles until
  // out_valid. Leaves the unit in DONE with out_ready low.
  task automatic applyStimulus(input int u, input logic [15:0] x,
                               output int lat);
    int n;
    @(negedge clk);
    den_in[u]   = x;
    in_valid[u] = 1'b1;
    n = 0;
    while (!in_ready[u] && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid[u] = 1'b0;
    den_in[u]   = 16'($urandom);
    n = 0;
    while (!out_valid[u] && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    lat = n + 1;
  endtask

  task automatic consume(input int u);
    @(negedge clk);
    out_ready[u] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_out_valid", int'(out_valid[u]), 0);
    checkOutput("release_in_ready", int'(in_ready[u]), 1);
    @(negedge clk);
    out_ready[u] = 1'b0;
  endtask

  task automatic verifyOp(input int u, input logic [15:0] x, input int expD,
                          input int expSh, input bit expZ, input bit expS,
                          input int expLat);
    int lat;
    applyStimulus(u, x, lat);
    checkOutput("latency", lat, expLat);
    checkOutput("den_out", int'(den_out[u]), expD);
    checkOutput("shift_out", int'($signed(shift_out[u])), expSh);
    checkOutput("zero_out", int'(zero_out[u]), int'(expZ));
    checkOutput("sat_out", int'(sat_out[u]), int'(expS));
  endtask

  task automatic checkResetState(input int u);
    checkOutput("rst_in_ready", int'(in_ready[u]), 1);
    checkOutput("rst_out_valid", int'(out_valid[u]), 0);
    checkOutput("rst_den_out", int'(den_out[u]), 0);
    checkOutput("rst_shift_out", int'(shift_out[u]), 0);
    checkOutput("rst_flags", int'({zero_out[u], sat_out[u]}), 0);
  endtask

  initial begin
    vec_t vecs[$];
    int d, sh, lat, stable, stale;
    bit z, s;
    logic [15:0] x;

    for (int u = 0; u < 2; u++) begin
      in_valid[u] = 1'b0; den_in[u] = '0; out_ready[u] = 1'b0;
    end
    rst = 1'b1;
    #1;
    checkResetState(0);
    checkResetState(1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{0, 16'd20000, 20000,  0, 1'b0, 1'b0, 2});
    vecs.push_back('{0, 16'd40000, 20000, -1, 1'b0, 1'b0, 2});
    vecs.push_back('{0, 16'd1,     16384, 14, 1'b0, 1'b0, STEP4 ? 7 : 16});
    vecs.push_back('{0, 16'd0,     0,      0, 1'b1, 1'b0, 2});
    vecs.push_back('{0, 16'd65535, 32767, -1, 1'b0, 1'b0, 2});
    vecs.push_back('{0, 16'd16384, 16384,  0, 1'b0, 1'b0, 2});
    vecs.push_back('{0, 16'd32767, 32767,  0, 1'b0, 1'b0, 2});
    vecs.push_back('{0, 16'd8192,  16384,  1, 1'b0, 1'b0, 3});
    vecs.push_back('{0, 16'd3,     24576, 13, 1'b0, 1'b0, STEP4 ? 6 : 15});
    vecs.push_back('{1, 16'd3,     768,    8, 1'b0, 1'b1, STEP4 ? 4 : 10});
    vecs.push_back('{1, 16'd1,     256,    8, 1'b0, 1'b1, STEP4 ? 4 : 10});
    vecs.push_back('{1, 16'd20000, 20000,  0, 1'b0, 1'b0, 2});
    vecs.push_back('{1, 16'd0,     0,      0, 1'b1, 1'b0, 2});
    vecs.push_back('{1, 16'd4096,  16384,  2, 1'b0, 1'b0, 4});

    foreach (vecs[i]) begin
      verifyOp(vecs[i].unit, vecs[i].den, vecs[i].expDen, vecs[i].expShift,
               vecs[i].expZero, vecs[i].expSat, vecs[i].expLat);
      consume(vecs[i].unit);
    end

    // Random operands with a random magnitude so every shift count appears.
    for (int i = 0; i < 40; i++) begin
      int u;
      u = i % 2;
      x = 16'($urandom & ((32'd1 << $urandom_range(0, 16)) - 32'd1));
      refModel(x, maxShift[u], d, sh, z, s, lat);
      verifyOp(u, x, d, sh, z, s, lat);
      consume(u);
    end

    // Back-pressure: result must hold for 10 cycles while a new operand is
    // offered and ignored.
    verifyOp(0, 16'd12345, 24690, 1, 1'b0, 1'b0, 3);
    stable = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid[0] = 1'b1;
      den_in[0]   = 16'd999;
      @(posedge clk);
      #1;
      if (!(out_valid[0] && !in_ready[0] && den_out[0] == 16'd24690 &&
            shift_out[0] == 5'd1)) stable = 0;
    end
    checkOutput("hold_stable", stable, 1);
    @(negedge clk);
    in_valid[0] = 1'b0;
    consume(0);
    verifyOp(0, 16'd40000, 20000, -1, 1'b0, 1'b0, 2);
    consume(0);

    // Reset in the middle of shifting abandons the operand.
    @(negedge clk);
    den_in[0]   = 16'd5;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetState(0);
    @(negedge clk);
    rst = 1'b0;
    stale = 0;
    repeat (16) begin
      @(posedge clk);
      #1;
      if (out_valid[0] || !in_ready[0]) stale = 1;
    end
    checkOutput("no_stale_result", stale, 0);
    verifyOp(0, 16'd20000, 20000, 0, 1'b0, 1'b0, 2);
    consume(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/den_norm_seq.md
Name: den_norm_seq

Overview:
- Sequential, parametrised normaliser for the unsigned denominator that feeds the CORDIC divide stage of the sigmoid datapath.
- Shifts the operand until it lies in the window [2^(W-2), 2^(W-1)).
- Reports the signed shift count so the downstream stage can de-normalise the quotient.
- Generalises the old fixed 16-bit combinational shift decode:
  - any width;
  - left and right shifts;
  - zero detection;
  - shift saturation;
  - valid/ready handshakes on both sides.

Parameters:
- W, 16, operand width in bits (W >= 4).
- MAX_SHIFT, W-2, maximum cumulative left shift before saturation (1..W-2).
- SW, $clog2(W)+1, width of the signed shift output (derived; not to be overridden).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  den_in is valid
- in_ready  out  1  block can accept an operand
- den_in  in  W  unsigned denominator
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- den_out  out  W  normalised value
- shift_out  out  SW  signed two's-complement shift count: +k = k left shifts, -1 = one right shift
- zero_out  out  1  den_in was 0
- sat_out  out  1  left shifting stopped at MAX_SHIFT before reaching the window

Behaviour:
- Reset (asynchronous, active-high):
  - state=IDLE;
  - in_ready=1, out_valid=0;
  - den_out=0, shift_out=0, zero_out=0, sat_out=0;
  - the internal value register and shift counter are cleared.
  - Reset mid-operation abandons the operand; no output is produced for it.
- States: IDLE, SHIFT, DONE.
  - in_ready=1 only in IDLE.
  - out_valid=1 only in DONE.
- IDLE:
  - Transfer occurs on an edge with in_valid && in_ready.
  - On transfer: capture den_in, clear the counter, clear the flags, go to SHIFT.
- SHIFT, evaluated once per clock edge, in this priority:
  1. value==0 -> zero_out=1, den_out=0, shift_out=0, go DONE.
  2. bit W-1 set -> value>>=1 (truncate LSB), shift=-1, go DONE.
     - The result is guaranteed in-window, so this takes no extra cycle.
  3. bit W-2 set (in window) -> go DONE.
  4. counter==MAX_SHIFT -> sat_out=1, go DONE with the current value.
  5. Otherwise value<<=1, counter+=1, remain in SHIFT.
- On DONE entry: den_out and shift_out are registered from the internal value and counter.
- Latency, where the transfer happens at the edge closing cycle T:
  - in-window input: out_valid in cycle T+2;
  - right-shift case: out_valid in cycle T+2;
  - k left shifts: out_valid in cycle T+2+k;
  - zero input: out_valid in cycle T+2.
- DONE:
  - Outputs are held stable while out_valid && !out_ready.
  - Transfer occurs on an edge with out_ready=1; go to IDLE.
  - out_valid deasserts in the next cycle and in_ready reasserts in the same cycle.
  - No bypass: the minimum accept-to-accept period is 3 cycles.
- Widths:
  - The counter is unsigned with $clog2(W)+1 bits and never exceeds MAX_SHIFT.
  - shift_out is sign-extended to SW bits.
- in_valid while not in IDLE is ignored; den_in is not sampled.

Optional Feature:
- Macro: DEN_NORM_STEP4_EN.
- When defined, in SHIFT step 5 becomes:
  - if bits [W-1:W-5] are all zero and counter+4 <= MAX_SHIFT: value<<=4, counter+=4;
  - otherwise: shift by 1 as before.
- Priority rules 1–4 are unchanged.
- This gives a worst-case latency of roughly (W-2)/4 + 3 cycles.
- Results are bit-identical to the undefined build for every input, including saturation; only latency differs.
- When undefined: one-bit steps only, and no step-4 logic is synthesised.

Test Plan:
All scenarios use W=16 and MAX_SHIFT=14 unless stated.
1. den_in=20000 -> den_out=20000, shift_out=0, zero_out=0, sat_out=0, out_valid at T+2.
2. den_in=40000 -> den_out=20000, shift_out=-1 (5'b11111), out_valid at T+2.
3. den_in=1 -> den_out=16384, shift_out=14:
   - out_valid at T+16 (macro undefined);
   - out_valid at T+7 (DEN_NORM_STEP4_EN defined).
4. den_in=0 -> zero_out=1, den_out=0, shift_out=0, out_valid at T+2. Then MAX_SHIFT=8, den_in=3 -> den_out=768, shift_out=8, sat_out=1, in both macro builds.
5. Hold out_ready=0 for 10 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored. Raise out_ready -> IDLE next cycle, and the next operand is accepted.
6. Assert rst while in SHIFT with den_in=5 -> all outputs are at reset values immediately. After release, den_in=20000 completes normally with shift_out=0, and no stale result appears.
